// File: rtl/bram_line_fetch.sv
// Framebuffer line scan-out: fetches one line of 32-bit words from a BRAM read port
// into a small word FIFO and serialises them LSB-first as 1 bpp pixels on pix_en.

module bram_line_fetch_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);

    push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

module bram_line_fetch #(
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WORDS = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  frame_start,
    input  logic                  line_req,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_clken,
    input  logic [31:0]           bram_dout,
    input  logic                  pix_en,
    output logic                  pix_out,
    output logic                  busy,
    output logic                  underrun
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 2;
    localparam int WL_W  = $clog2(LINE_WORDS + 1);

    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
    localparam logic [WL_W-1:0]       LINE_C  = WL_W'(LINE_WORDS);
    localparam logic [WL_W-1:0]       WL_ONE  = WL_W'(1);
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] line_ptr_r;
    logic [ADDR_WIDTH-1:0] fetch_addr_r;
    logic [ADDR_WIDTH-1:0] last_addr_r;
    logic [ADDR_WIDTH-1:0] line_ptr_s;
    logic [WL_W-1:0]       words_left_r;
    logic                  inflight_r;

    logic [31:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic [31:0]           shifter_r;
    logic [4:0]            idx_r;
    logic                  sh_valid_r;
    logic                  pix_r;
    logic                  underrun_r;

    logic                  flush_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic [CNT_W-1:0]      occupancy_s;

    // Issue, capture and shifter-load decisions for the current cycle
    always_comb begin
        flush_s     = frame_start | line_req;
        occupancy_s = count_r + {{(CNT_W-1){1'b0}}, inflight_r};
        if (frame_start) begin
            line_ptr_s = base_addr;
        end else begin
            line_ptr_s = line_ptr_r;
        end
        issue_s = (state_r == FETCH) && (words_left_r != {WL_W{1'b0}}) &&
                  !flush_s && (occupancy_s < DEPTH_C);
        // a read still in flight across a flush returns stale data and is dropped
        push_s  = inflight_r & ~flush_s;
        pop_s   = !flush_s && (count_r != {CNT_W{1'b0}}) &&
                  (!sh_valid_r || (pix_en && (idx_r == 5'd31)));
        full_s  = (count_r == DEPTH_C);
    end

    // The BRAM samples address and enable at the edge closing the issue cycle
    assign bram_clken = issue_s;
    assign bram_addr  = issue_s ? fetch_addr_r : last_addr_r;
    assign busy       = (state_r == FETCH);
    assign pix_out    = pix_r;
    assign underrun   = underrun_r;

    // Line pointer, fetch pointer and IDLE/FETCH sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            line_ptr_r   <= {ADDR_WIDTH{1'b0}};
            fetch_addr_r <= {ADDR_WIDTH{1'b0}};
            last_addr_r  <= {ADDR_WIDTH{1'b0}};
            words_left_r <= {WL_W{1'b0}};
            inflight_r   <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                last_addr_r  <= fetch_addr_r;
                fetch_addr_r <= fetch_addr_r + ADR_ONE;
                words_left_r <= words_left_r - WL_ONE;
                if (words_left_r == WL_ONE) begin
                    state_r <= IDLE;
                end
            end
            if (frame_start) begin
                line_ptr_r <= base_addr;
                state_r    <= IDLE;
            end
            if (line_req) begin
                fetch_addr_r <= line_ptr_s;
                line_ptr_r   <= line_ptr_s + STEP_C;
                words_left_r <= LINE_C;
                state_r      <= FETCH;
            end
        end
    end

    // FIFO storage, written only by accepted read returns
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_r] <= bram_dout;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Pixel shifter, registered pixel output and sticky underrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter_r  <= 32'd0;
            idx_r      <= 5'd0;
            sh_valid_r <= 1'b0;
            pix_r      <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (pix_en) begin
                if (sh_valid_r) begin
                    pix_r <= shifter_r[idx_r];
                    idx_r <= idx_r + 5'd1;
                    if (idx_r == 5'd31) begin
                        sh_valid_r <= 1'b0;
                    end
                end else begin
                    pix_r      <= 1'b0;
                    underrun_r <= 1'b1;
                end
            end
            // a reload on the last bit keeps output gapless
            if (pop_s) begin
                shifter_r  <= fifo_mem[rd_ptr_r];
                idx_r      <= 5'd0;
                sh_valid_r <= 1'b1;
            end
            if (flush_s) begin
                sh_valid_r <= 1'b0;
            end
            if (frame_start) begin
                underrun_r <= 1'b0;
            end
        end
    end

    bram_line_fetch_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (full_s)
    );

endmodule

// File: tb/tb_bram_line_fetch.sv
// Bench for bram_line_fetch: table-driven frame scenarios, hand-written corner
// sequences and randomized frames checked against a pixel/address reference model.

module tb_bram_line_fetch;

    localparam int AW = 12;
    localparam int LW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] base_addr;
    logic          frame_start;
    logic          line_req;
    logic [AW-1:0] bram_addr;
    logic          bram_clken;
    logic [31:0]   bram_dout;
    logic          pix_en;
    logic          pix_out;
    logic          busy;
    logic          underrun;

    logic [31:0]   mem [0:4095];
    logic [AW-1:0] issue_q [$];
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic [AW-1:0] base;
        int            lines;
        int            hold;
        logic [AW-1:0] last_first;
    } vec_t;

    bram_line_fetch #(.ADDR_WIDTH(AW), .LINE_WORDS(LW), .FIFO_DEPTH(FD)) dut (
        .clk         (clk),
        .rst         (rst),
        .base_addr   (base_addr),
        .frame_start (frame_start),
        .line_req    (line_req),
        .bram_addr   (bram_addr),
        .bram_clken  (bram_clken),
        .bram_dout   (bram_dout),
        .pix_en      (pix_en),
        .pix_out     (pix_out),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // BRAM read port model: one cycle latency, no output register
    always @(posedge clk) begin
        if (bram_clken) bram_dout <= mem[bram_addr];
    end

    // Record every address issued to the BRAM
    always @(posedge clk) begin
        if (!rst && bram_clken) issue_q.push_back(bram_addr);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_identity();
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    endtask

    task automatic do_frame_start(input logic [AW-1:0] b);
        base_addr   = b;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Expected pixel p of the line whose first word is at lb
    function automatic logic exp_pix(input int lb, input int p);
        logic [31:0] w;
        w = mem[(lb + p / 32) % 4096];
        return w[p % 32];
    endfunction

    task automatic run_line(input int lb, input int hold, input bit gaps);
        int n;
        bit pe;
        issue_q.delete();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        chk("busy_fetch", {31'd0, busy}, 32'd1);
        for (int i = 0; i < hold; i++) tick();
        if (hold >= 10) chk("stall_issues", issue_q.size(), FD + 1);
        n = 0;
        for (int it = 0; it < 20000 && n < 1024; it++) begin
            pe = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_en = pe;
            tick();
            if (pe) begin
                chk("pixel", {31'd0, pix_out}, {31'd0, exp_pix(lb, n)});
                n++;
            end
        end
        pix_en = 1'b0;
        chk("pixels_done", n, 1024);
        tick();
        tick();
        chk("issue_count", issue_q.size(), LW);
        for (int i = 0; i < issue_q.size(); i++)
            chk("issue_addr", {20'd0, issue_q[i]}, 32'((lb + i) % 4096));
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("underrun_clear", {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{12'h100, 1, 6, 12'h100};
        vecs[1] = '{12'h100, 1, 50, 12'h100};
        vecs[2] = '{12'hFF0, 2, 6, 12'h010};
        vecs[3] = '{12'hFE5, 3, 12, 12'h025};

        mem_identity();
        rst = 1'b1; base_addr = '0; frame_start = 1'b0; line_req = 1'b0; pix_en = 1'b0;
        tick();
        tick();
        chk("rst_pix_out", {31'd0, pix_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_clken", {31'd0, bram_clken}, 32'd0);
        chk("rst_addr", {20'd0, bram_addr}, 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            do_frame_start(vecs[v].base);
            for (int l = 0; l < vecs[v].lines; l++)
                run_line((int'(vecs[v].base) + LW * l) % 4096, vecs[v].hold, 1'b0);
            chk("last_line_first", {20'd0, issue_q[0]}, {20'd0, vecs[v].last_first});
        end

        // abort while the first read of 0x300 is still in flight
        do_frame_start(12'h300);
        issue_q.delete();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        tick();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        chk("abort_old_issues", issue_q.size(), 1);
        for (int i = 0; i < 8; i++) tick();
        chk("abort_old_addr", {20'd0, issue_q[0]}, 32'h300);
        chk("abort_new_addr", {20'd0, issue_q[1]}, 32'h320);
        for (int n = 0; n < 64; n++) begin
            pix_en = 1'b1;
            tick();
            chk("abort_pixel", {31'd0, pix_out}, {31'd0, exp_pix(12'h320, n)});
        end
        pix_en = 1'b0;
        chk("abort_underrun", {31'd0, underrun}, 32'd0);

        // pix_en from the first cycle after line_req: three starved strobes
        do_frame_start(12'h0A5);
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        pix_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("starve_pix", {31'd0, pix_out}, 32'd0);
            chk("starve_underrun", {31'd0, underrun}, 32'd1);
        end
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("late_pixel", {31'd0, pix_out}, {31'd0, exp_pix(12'h0A5, n)});
        end
        pix_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);
        do_frame_start(12'h000);
        chk("underrun_cleared", {31'd0, underrun}, 32'd0);

        // frame_start and line_req in the same cycle
        issue_q.delete();
        base_addr = 12'h200;
        frame_start = 1'b1;
        line_req = 1'b1;
        tick();
        frame_start = 1'b0;
        line_req = 1'b0;
        tick();
        chk("coinc_seen", {31'd0, issue_q.size() > 0}, 32'd1);
        if (issue_q.size() > 0) chk("coinc_first", {20'd0, issue_q[0]}, 32'h200);
        issue_q.delete();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        tick();
        chk("coinc_next_seen", {31'd0, issue_q.size() > 0}, 32'd1);
        if (issue_q.size() > 0) chk("coinc_next", {20'd0, issue_q[0]}, 32'h220);

        // randomized frames with random data and random pixel gaps
        for (int r = 0; r < 4; r++) begin
            int b;
            int nl;
            b = $urandom_range(0, 4095);
            for (int i = 0; i < 4096; i++) mem[i] = $urandom;
            do_frame_start(12'(b));
            nl = $urandom_range(1, 2);
            for (int l = 0; l < nl; l++)
                run_line((b + LW * l) % 4096, $urandom_range(6, 30), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
